// File: rtl/mux_scan_pkg.sv
`default_nettype none
// Shared types and constants for mux_scan_ctrl.
// Scan order is selected by MUX_SCAN_MSB_FIRST_EN (defined: 7..0, undefined: 0..7).
package mux_scan_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam int WORD_W   = 8;
  localparam int SEL_W    = 3;
  localparam int HOLD_MAX = 16;
  localparam int HCNT_W   = $clog2(HOLD_MAX);

`ifdef MUX_SCAN_MSB_FIRST_EN
  localparam logic [SEL_W-1:0] FIRST_IDX = 3'd7;
  localparam logic [SEL_W-1:0] LAST_IDX  = 3'd0;

  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
    return idx - SEL_W'(1);
  endfunction
`else
  localparam logic [SEL_W-1:0] FIRST_IDX = 3'd0;
  localparam logic [SEL_W-1:0] LAST_IDX  = 3'd7;

  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
    return idx + SEL_W'(1);
  endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/mux8_1.sv
`default_nettype none
// mux8_1: 8-to-1 bit multiplexer, y0 = i[sel].
module mux8_1
  import mux_scan_pkg::*;
(
  input  logic [WORD_W-1:0] i,
  input  logic [SEL_W-1:0]  sel,
  output logic              y0
);

  assign y0 = i[sel];

endmodule
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// mux_scan_ctrl: captures an 8-bit word and presents it bit by bit on ser_out,
// each bit for HOLD_CYCLES cycles. Scan order set by MUX_SCAN_MSB_FIRST_EN.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SEL_W-1:0]  sel_out,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_last,
  output logic              busy
);

  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYCLES - 1);

  state_t              state, state_nxt;
  logic [WORD_W-1:0]   word_reg, word_nxt;
  logic [SEL_W-1:0]    sel_nxt;
  logic [HCNT_W-1:0]   hold_cnt, hold_nxt;
  logic                mux_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      word_reg <= '0;
      sel_out  <= FIRST_IDX;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      word_reg <= word_nxt;
      sel_out  <= sel_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    word_nxt  = word_reg;
    sel_nxt   = sel_out;
    hold_nxt  = hold_cnt;
    in_ready  = 1'b0;
    busy      = 1'b0;
    ser_valid = 1'b0;
    ser_last  = 1'b0;
    case (state)
      IDLE: begin
        // in_ready drops combinationally with rst so no word is offered during reset
        in_ready = ~rst;
        if (in_valid && in_ready) begin
          word_nxt  = in_data;
          sel_nxt   = FIRST_IDX;
          hold_nxt  = '0;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        busy      = 1'b1;
        ser_valid = 1'b1;
        ser_last  = (sel_out == LAST_IDX);
        if (hold_cnt == HOLD_LAST) begin
          hold_nxt = '0;
          if (sel_out == LAST_IDX) begin
            state_nxt = IDLE;
            sel_nxt   = FIRST_IDX;
          end else begin
            sel_nxt = next_idx(sel_out);
          end
        end else begin
          hold_nxt = hold_cnt + HCNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  mux8_1 u_mux (
    .i   (word_reg),
    .sel (sel_out),
    .y0  (mux_y)
  );

  assign ser_out = mux_y & ser_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// Self-checking bench for mux_scan_ctrl: a HOLD_CYCLES=1 and a HOLD_CYCLES=3 instance
// checked every cycle against a queue-of-expected-beats reference model.
module tb_mux_scan_ctrl;

  typedef struct packed {
    logic       b;
    logic [2:0] idx;
    logic       last;
  } beat_t;

`ifdef MUX_SCAN_MSB_FIRST_EN
  localparam logic [2:0] EXP_FIRST = 3'd7;
`else
  localparam logic [2:0] EXP_FIRST = 3'd0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid1 = 1'b0;
  logic       valid3 = 1'b0;
  int         active = 1;
  int         n_assert = 0;
  int         n_fail = 0;
  int         n_valid = 0;

  logic       rdy1, so1, sv1, sl1, busy1;
  logic [2:0] sel1;
  logic       rdy3, so3, sv3, sl3, busy3;
  logic [2:0] sel3;

  beat_t q1[$];
  beat_t q3[$];

  always #5 clk = ~clk;

  mux_scan_ctrl #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(data), .in_valid(valid1), .in_ready(rdy1),
    .sel_out(sel1), .ser_out(so1), .ser_valid(sv1), .ser_last(sl1), .busy(busy1)
  );

  mux_scan_ctrl #(.HOLD_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(data), .in_valid(valid3), .in_ready(rdy3),
    .sel_out(sel3), .ser_out(so3), .ser_valid(sv3), .ser_last(sl3), .busy(busy3)
  );

  function automatic logic [2:0] scan_idx(input int k);
`ifdef MUX_SCAN_MSB_FIRST_EN
    return 3'(7 - k);
`else
    return 3'(k);
`endif
  endfunction

  // Reference: an accepted word becomes 8*HOLD expected beats; one beat consumed per cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) q1.delete();
    else if (q1.size() == 0) begin
      if (valid1)
        for (int k = 0; k < 8; k++)
          q1.push_back(beat_t'{b: data[scan_idx(k)], idx: scan_idx(k), last: (k == 7)});
    end else void'(q1.pop_front());
  end

  always @(posedge clk or posedge rst) begin
    if (rst) q3.delete();
    else if (q3.size() == 0) begin
      if (valid3)
        for (int k = 0; k < 8; k++)
          for (int h = 0; h < 3; h++)
            q3.push_back(beat_t'{b: data[scan_idx(k)], idx: scan_idx(k), last: (k == 7)});
    end else void'(q3.pop_front());
  end

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check();
    int    n;
    beat_t e;
    logic  ex_v, ex_b, ex_l, ex_r;
    logic [2:0] ex_s;
    n = (active == 3) ? q3.size() : q1.size();
    if (n > 0) begin
      e    = (active == 3) ? q3[0] : q1[0];
      ex_v = 1'b1; ex_b = e.b; ex_s = e.idx; ex_l = e.last; ex_r = 1'b0;
    end else begin
      ex_v = 1'b0; ex_b = 1'b0; ex_s = EXP_FIRST; ex_l = 1'b0; ex_r = ~rst;
    end
    if (active == 3) begin
      cmp("h3_in_ready", 8'(rdy3), 8'(ex_r));
      cmp("h3_busy", 8'(busy3), 8'(ex_v));
      cmp("h3_ser_valid", 8'(sv3), 8'(ex_v));
      cmp("h3_ser_out", 8'(so3), 8'(ex_b));
      cmp("h3_ser_last", 8'(sl3), 8'(ex_l));
      cmp("h3_sel_out", 8'(sel3), 8'(ex_s));
      if (sv3) n_valid++;
    end else begin
      cmp("h1_in_ready", 8'(rdy1), 8'(ex_r));
      cmp("h1_busy", 8'(busy1), 8'(ex_v));
      cmp("h1_ser_valid", 8'(sv1), 8'(ex_v));
      cmp("h1_ser_out", 8'(so1), 8'(ex_b));
      cmp("h1_ser_last", 8'(sl1), 8'(ex_l));
      cmp("h1_sel_out", 8'(sel1), 8'(ex_s));
      if (sv1) n_valid++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset state of both instances
    active = 1; ticks(2);
    active = 3; tick();
    active = 1;
    @(posedge clk); #1 rst = 1'b0;

    // Idle with in_valid low and toggling data: no capture
    for (int i = 0; i < 4; i++) begin
      data = 8'($urandom);
      tick();
    end

    // 8'hAA, HOLD=1
    n_valid = 0;
    data = 8'hAA; valid1 = 1'b1; tick(); valid1 = 1'b0;
    ticks(8);
    cmp("aa_valid_count", 8'(n_valid), 8'd8);

    // 8'h81, HOLD=3
    active = 3; n_valid = 0;
    data = 8'h81; valid3 = 1'b1; tick(); valid3 = 1'b0;
    ticks(25);
    cmp("h3_valid_count", 8'(n_valid), 8'd24);

    // Back-to-back with in_valid held high
    active = 1; n_valid = 0;
    data = 8'hF0; valid1 = 1'b1; tick();
    data = 8'h0F;
    ticks(16);
    valid1 = 1'b0;
    ticks(2);
    cmp("b2b_valid_count", 8'(n_valid), 8'd16);

    // Reset during the 4th bit of 8'hFF
    data = 8'hFF; valid1 = 1'b1; tick(); valid1 = 1'b0;
    ticks(3);
    #1 rst = 1'b1;
    #1 check();
    @(posedge clk); #1 rst = 1'b0;
    data = 8'h01; valid1 = 1'b1;
    tick();
    tick(); valid1 = 1'b0;
    ticks(8);

    // Randomized traffic on both instances
    for (int i = 0; i < 150; i++) begin
      data = 8'($urandom);
      valid1 = ($urandom_range(0, 3) == 0);
      tick();
    end
    valid1 = 1'b0; ticks(10);
    active = 3;
    for (int i = 0; i < 200; i++) begin
      data = 8'($urandom);
      valid3 = ($urandom_range(0, 3) == 0);
      tick();
    end
    valid3 = 1'b0; ticks(26);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
